// File: rtl/d_sram_axi_bridge_if.sv
// Signal bundle between the sram-like data-cache port and the AXI3 master port of
// d_sram_axi_bridge. The master modport is the bridge view; slave is the cache plus AXI slave.
interface d_sram_axi_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/d_sram_axi_bridge.sv
// Single-outstanding sram-like to AXI3 bridge for the data cache.
// Optional macro D_BRIDGE_WR_RESP_WAIT_EN: write data_ok waits for the B response.
module d_sram_axi_bridge #(
  parameter logic [3:0] ID_VAL = 4'b0001
) (
  input logic               clk,
  input logic               rst,
  d_sram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP
  } state_t;

  state_t      state, state_nxt;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        aw_done, w_done;
  logic        accept, aw_hs, w_hs, aw_fin, w_fin;
  logic        unused_resp;

  // Size code 11 has no meaning on this port; it is handled as a word access.
  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.data_req && !rst;
  assign aw_hs  = (state == WR_ADDR_DATA) && !aw_done && bus.awready;
  assign w_hs   = (state == WR_ADDR_DATA) && !w_done && bus.wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_r    <= bus.data_wr;
        size_r  <= clamp_size(bus.data_size);
        addr_r  <= bus.data_addr;
        wdata_r <= bus.data_wdata;
      end
      // Per-channel completion flags live only while both channels are still open.
      if (state == WR_ADDR_DATA && !(aw_fin && w_fin)) begin
        aw_done <= aw_fin;
        w_done  <= w_fin;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.arvalid      = 1'b0;
    bus.rready       = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;
    case (state)
      IDLE: begin
        bus.data_addr_ok = accept;
        if (accept) state_nxt = bus.data_wr ? WR_ADDR_DATA : RD_ADDR;
      end
      RD_ADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          bus.data_data_ok = 1'b1;
          state_nxt        = IDLE;
        end
      end
      WR_ADDR_DATA: begin
        bus.awvalid = !aw_done;
        bus.wvalid  = !w_done;
        if (aw_fin && w_fin) begin
          state_nxt = WR_RESP;
`ifndef D_BRIDGE_WR_RESP_WAIT_EN
          bus.data_data_ok = 1'b1;
`endif
        end
      end
      WR_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          state_nxt = IDLE;
`ifdef D_BRIDGE_WR_RESP_WAIT_EN
          bus.data_data_ok = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data_rdata = bus.rdata;

  assign bus.arid    = ID_VAL;
  assign bus.araddr  = addr_r;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_r};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;

  assign bus.awid    = ID_VAL;
  assign bus.awaddr  = addr_r;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, size_r};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;

  assign bus.wid   = ID_VAL;
  assign bus.wdata = wdata_r;
  assign bus.wstrb = strb_of(size_r, addr_r[1:0]);
  assign bus.wlast = 1'b1;

  // Response codes, ids and rlast carry nothing this single-beat bridge acts on.
  assign unused_resp = ^{bus.rresp, bus.rid, bus.rlast, bus.bresp, bus.bid, wr_r};

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Scoreboard bench for d_sram_axi_bridge: a scripted cache master and AXI slave with
// configurable handshake delays; expected beats are queued at request time.
module tb_d_sram_axi_bridge;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_ar  = 0;
  int   n_ovl = 0;
  int   n_both = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
  } addr_exp_t;
  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } w_exp_t;

  addr_exp_t   q_addr[$];
  w_exp_t      q_w[$];
  logic [31:0] q_rd[$];

  d_sram_axi_bridge_if bus ();

  d_sram_axi_bridge #(.ID_VAL(4'b0001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [1:0] sz);
    if (sz == 2'b11) return 3'b010;
    return {1'b0, sz};
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] byte_lane [4];
    byte_lane = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    if (sz == 2'b00) return byte_lane[a];
    if (sz == 2'b01) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic quiet();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = $urandom;
    bus.rid     = 4'($urandom);
    bus.rresp   = 2'($urandom);
    bus.rlast   = 1'($urandom);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = 4'($urandom);
    bus.bresp   = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      quiet();
      bus.data_req = 1'b0;
      #1;
      chk("idle_dok", bus.data_data_ok, 1'b0);
    end
  endtask

  // Present a request until accepted; returns cycles waited.
  task automatic request(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int waited, output bit ok);
    waited = 0;
    ok = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      quiet();
      bus.data_req   = 1'b1;
      bus.data_wr    = wr;
      bus.data_size  = sz;
      bus.data_addr  = a;
      bus.data_wdata = d;
      #1;
      if (bus.data_addr_ok) ok = 1;
      else waited++;
    end
    chk("req_accept", ok, 1'b1);
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input int ar_dly, input int r_dly, input bit imm);
    int waited, n, dok;
    bit ok, done;
    addr_exp_t e;
    request(1'b0, sz, a, 32'h0, waited, ok);
    if (imm) chk("rd_b2b_latency", waited, 0);
    q_addr.push_back('{addr: a, size: exp_size(sz)});
    q_rd.push_back(d);
    dok = 0;
    n = 0;
    done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      quiet();
      bus.arready = bus.arvalid && (n >= ar_dly);
      #1;
      chk("rd_hold_aok", bus.data_addr_ok, 1'b0);
      dok += int'(bus.data_data_ok);
      if (bus.arvalid && bus.arready) begin
        done = 1;
        if (q_addr.size() == 0) chk("sb_addr_underflow", 1'b1, 1'b0);
        else begin
          e = q_addr.pop_front();
          chk("araddr", bus.araddr, e.addr);
          chk("arsize", bus.arsize, e.size);
          chk("ar_consts", {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
              {4'b0001, 8'd0, 2'b01, 2'b00, 4'b0000, 3'b000});
        end
      end
      n++;
    end
    if (!done) chk("ar_timeout", 1'b0, 1'b1);
    n = 0;
    done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      quiet();
      bus.rvalid = (n >= r_dly);
      if (bus.rvalid) bus.rdata = d;
      #1;
      chk("rd_hold_aok", bus.data_addr_ok, 1'b0);
      dok += int'(bus.data_data_ok);
      if (bus.rvalid) begin
        done = 1;
        chk("rready", bus.rready, 1'b1);
        chk("rd_dok", bus.data_data_ok, 1'b1);
        if (q_rd.size() == 0) chk("sb_rd_underflow", 1'b1, 1'b0);
        else chk("rdata", bus.data_rdata, q_rd.pop_front());
      end
      n++;
    end
    if (!done) chk("r_timeout", 1'b0, 1'b1);
    chk("rd_dok_once", dok, 1);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input int aw_dly, input int w_dly, input int b_dly,
                       input bit imm, input bit pend);
    int waited, n;
    bit ok, aw_ok, w_ok, hs_aw, hs_w, done;
    addr_exp_t e;
    w_exp_t we;
    logic exp_dok;
    request(1'b1, sz, a, d, waited, ok);
    if (imm) chk("wr_b2b_latency", waited, 0);
    q_addr.push_back('{addr: a, size: exp_size(sz)});
    q_w.push_back('{strb: exp_strb(sz, a[1:0]), data: d});
    aw_ok = 0;
    w_ok = 0;
    n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      @(negedge clk);
      quiet();
      bus.awready = bus.awvalid && (n >= aw_dly);
      bus.wready  = bus.wvalid && (n >= w_dly);
      #1;
      chk("wr_hold_aok", bus.data_addr_ok, 1'b0);
      chk("bready_early", bus.bready, 1'b0);
      if (n == 0) chk("aw_w_together", {bus.awvalid, bus.wvalid}, 2'b11);
      if (aw_ok) chk("awvalid_drop", bus.awvalid, 1'b0);
      if (w_ok) chk("wvalid_drop", bus.wvalid, 1'b0);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      if (hs_aw) begin
        aw_ok = 1;
        if (q_addr.size() == 0) chk("sb_addr_underflow", 1'b1, 1'b0);
        else begin
          e = q_addr.pop_front();
          chk("awaddr", bus.awaddr, e.addr);
          chk("awsize", bus.awsize, e.size);
          chk("aw_consts", {bus.awid, bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot},
              {4'b0001, 8'd0, 2'b01, 2'b00, 4'b0000, 3'b000});
        end
      end
      if (hs_w) begin
        w_ok = 1;
        if (q_w.size() == 0) chk("sb_w_underflow", 1'b1, 1'b0);
        else begin
          we = q_w.pop_front();
          chk("wstrb", bus.wstrb, we.strb);
          chk("wdata", bus.wdata, we.data);
          chk("w_consts", {bus.wid, bus.wlast}, {4'b0001, 1'b1});
        end
      end
`ifdef D_BRIDGE_WR_RESP_WAIT_EN
      exp_dok = 1'b0;
`else
      exp_dok = aw_ok && w_ok;
`endif
      chk("wr_dok_addr_data", bus.data_data_ok, exp_dok);
      n++;
    end
    if (!(aw_ok && w_ok)) chk("aw_w_timeout", 1'b0, 1'b1);
    n = 0;
    done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      quiet();
      bus.data_req = pend;
      bus.data_wr  = 1'b0;
      bus.bvalid   = (n >= b_dly);
      #1;
      chk("wr_bready", bus.bready, 1'b1);
      chk("wr_resp_aok", bus.data_addr_ok, 1'b0);
`ifdef D_BRIDGE_WR_RESP_WAIT_EN
      exp_dok = bus.bvalid;
`else
      exp_dok = 1'b0;
`endif
      chk("wr_dok_resp", bus.data_data_ok, exp_dok);
      if (bus.bvalid) done = 1;
      n++;
    end
    if (!done) chk("b_timeout", 1'b0, 1'b1);
  endtask

  task automatic reset_mid_ar();
    int waited, ar_before;
    bit ok;
    request(1'b0, 2'b10, 32'h2000_0000, 32'h0, waited, ok);
    @(negedge clk);
    quiet();
    bus.data_req = 1'b0;
    #1;
    chk("pre_rst_arvalid", bus.arvalid, 1'b1);
    ar_before = n_ar;
    @(negedge clk);
    rst = 1'b1;
    bus.data_req = 1'b1;
    #1;
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_outputs", {bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                        bus.data_addr_ok, bus.data_data_ok}, 6'b0);
    chk("rst_fields", {bus.araddr, bus.arsize}, 35'h0);
    @(negedge clk);
    bus.data_req = 1'b0;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      quiet();
      #1;
      chk("post_rst_no_ar", bus.arvalid, 1'b0);
    end
    chk("post_rst_ar_count", n_ar, ar_before);
  endtask

  // Background monitor: AR handshake count and forbidden overlaps.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.arvalid && bus.arready) n_ar++;
      if (bus.arvalid && (bus.awvalid || bus.wvalid)) n_ovl++;
      if (bus.data_data_ok && bus.data_addr_ok) n_both++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'b00;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    quiet();
    @(negedge clk);
    bus.data_req = 1'b1;
    #1;
    chk("reset_ctrl", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                       bus.data_addr_ok, bus.data_data_ok}, 7'b0);
    chk("reset_fields", {bus.awaddr, bus.wdata, bus.awsize}, 67'h0);
    @(negedge clk);
    bus.data_req = 1'b0;
    rst = 1'b0;
    idle(2);

    do_rd(32'h1000_0004, 2'b10, 32'hDEAD_BEEF, 1, 2, 1'b0);
    idle(1);
    do_wr(32'h0000_0013, 2'b00, 32'hABAB_ABAB, 0, 0, 0, 1'b0, 1'b0);
    idle(1);
    do_wr(32'h0000_0002, 2'b01, 32'h1234_5678, 0, 3, 1, 1'b0, 1'b0);
    idle(1);
    do_wr(32'h0000_0040, 2'b10, 32'hCAFE_F00D, 1, 1, 5, 1'b0, 1'b1);
    do_rd(32'h0000_0080, 2'b11, 32'h1122_3344, 0, 0, 1'b1);
    idle(1);
    do_wr(32'h0000_0100, 2'b01, 32'h0000_5A5A, 2, 0, 0, 1'b0, 1'b0);
    idle(1);
    do_wr(32'h0000_0201, 2'b00, 32'h0077_0000, 1, 2, 2, 1'b0, 1'b0);
    idle(1);
    do_rd(32'h0000_0300, 2'b10, 32'h0BAD_CAFE, 0, 1, 1'b0);
    do_wr(32'h0000_0304, 2'b10, 32'hFEED_FACE, 0, 0, 0, 1'b1, 1'b0);
    idle(1);
    reset_mid_ar();
    do_rd(32'h3000_0008, 2'b01, 32'h5555_AAAA, 0, 0, 1'b0);
    idle(2);

    chk("no_ar_aw_overlap", n_ovl, 0);
    chk("no_dok_in_idle", n_both, 0);
    chk("ar_handshakes", n_ar, 4);
    chk("sb_empty", q_addr.size() + q_w.size() + q_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_sram_axi_bridge.md
D_SRAM_AXI_BRIDGE -- requirements
Module: d_sram_axi_bridge

Interface
REQ-001 Parameter: ID_VAL, 4'b0001, constant driven on arid/awid/wid.
REQ-002 Ports, clock and reset first:
  clk  in  1  sole clock; all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  data_req  in  1  sram-like request from data cache.
  data_wr  in  1  1 = write, 0 = read.
  data_size  in  2  00 byte, 01 half, 10 word.
  data_addr  in  32  byte address.
  data_wdata  in  32  store data, lane-aligned.
  data_rdata  out  32  load data.
  data_addr_ok  out  1  request accepted.
  data_data_ok  out  1  transaction complete.
  ar*: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 (out); arready 1 (in).
  r*: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 (in); rready 1 (out).
  aw*: same widths as ar* (out); awready (in).
  w*: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1 (out); wready (in).
  b*: bid 4, bresp 2, bvalid 1 (in); bready 1 (out).
REQ-003 Clock and reset are fixed: one clock clk; rst asynchronous, active-high.

Function
REQ-004 At most one outstanding transaction; states IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
REQ-005 data_addr_ok = data_req in IDLE; acceptance latches wr, size, addr, wdata in the same edge.
REQ-006 Accepted read -> RD_ADDR: arvalid=1 with latched values until arready; then RD_DATA.
REQ-007 RD_DATA: rready=1; on rvalid: data_data_ok=1 same cycle, data_rdata=rdata (combinational), next state IDLE.
REQ-008 Accepted write -> WR_ADDR_DATA: awvalid and wvalid asserted together; each drops independently after its own handshake; both handshakes in one cycle allowed; state advances when both are done.
REQ-009 WR_RESP: bready=1; bvalid completes the transaction -> IDLE.
REQ-010 arsize/awsize = {1'b0, size}; size 11 treated as 10.
REQ-011 wstrb: byte -> 0001<<addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111; wdata = latched data_wdata unmodified.
REQ-012 Constants: arlen/awlen 0, arburst/awburst 01, arlock/awlock 0, arcache/awcache 0, arprot/awprot 0, wlast 1, ids ID_VAL.
REQ-013 rresp, bresp, rid, bid, rlast are ignored.
REQ-014 data_req held or re-asserted during a transaction gets no addr_ok until IDLE; data_data_ok is never asserted in IDLE.
REQ-015 Back-to-back requests: a request present in the IDLE cycle that follows completion is accepted in that cycle.

Reset
REQ-016 rst asserted at any time, including mid-handshake: state IDLE; arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok = 0; latched fields = 0; no transaction resumed after release.

Configuration
REQ-017 Macro D_BRIDGE_WR_RESP_WAIT_EN defined: write data_data_ok = bvalid in WR_RESP (per REQ-009).
REQ-018 Macro absent: write data_data_ok pulses for one cycle when the second of the AW/W handshakes completes; WR_RESP still consumes the B response, and addr_ok stays 0 until it does.

Verification
REQ-019 Read word 0x1000_0004, arready one cycle late, rvalid two cycles later with 0xDEADBEEF -> single araddr 0x1000_0004 arsize 010; data_ok=1 with rdata 0xDEADBEEF exactly once.
REQ-020 sb to 0x0000_0013, data 0x0000_AB00... lanes 0xABABABAB -> awaddr 0x0000_0013, awsize 000, wstrb 1000, wdata 0xABABABAB.
REQ-021 sh to 0x0000_0002: awready before wready (3 cycles apart) -> wstrb 1100; each valid drops after its own handshake; state enters WR_RESP only after wready.
REQ-022 Write, bvalid delayed 5 cycles -> macro defined: data_ok on bvalid cycle; macro absent: data_ok after W handshake, and a following read gets addr_ok only after bvalid.
REQ-023 rst pulsed while arvalid=1 awaiting arready -> arvalid falls immediately; after release no AR reissued until a new data_req.
REQ-024 Read then write issued back-to-back -> second request accepted in the IDLE cycle after the read's data_ok; no overlapping AR/AW.
